led_fade_driver: RTL and testbench

//  Output stage between the SoC LED register and the board LED pad buffers.

---
 rtl/led_fade_pkg.sv | 41 ++++
 rtl/led_fade_channel.sv | 69 ++++++
 rtl/led_fade_driver.sv | 93 +++++++++
 tb/tb_led_fade_driver.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_fade_pkg.sv
// Shared types and helpers for the LED fade/PWM output stage.
package led_fade_pkg;

  // Widest brightness the level helpers support; one extra bit gives step headroom.
  localparam int unsigned LVL_MAX_BITS = 16;
  localparam int unsigned LVL_W        = LVL_MAX_BITS + 1;

  // Default channel geometry.
  localparam int unsigned DEF_PWM_BITS = 8;
  localparam int unsigned DEF_MAX      = (1 << DEF_PWM_BITS) - 1;

  // Unlit pad level for an active-low board.
  localparam logic UNLIT_ACTIVE_LOW = 1'b1;

  typedef logic [LVL_W-1:0] lvl_t;

  // Move cur toward tgt by step, landing exactly on tgt instead of passing it.
  function automatic lvl_t step_toward(input lvl_t cur, input lvl_t tgt, input lvl_t step);
    lvl_t nxt;
    nxt = cur;
    if (cur < tgt) begin
      nxt = cur + step;
      if (nxt > tgt) begin
        nxt = tgt;
      end
    end else if (cur > tgt) begin
      if ((cur - tgt) <= step) begin
        nxt = tgt;
      end else begin
        nxt = cur - step;
      end
    end
    return nxt;
  endfunction

  // Pad drive level for a lit/unlit decision under the chosen polarity.
  function automatic logic pad_level(input logic lit, input logic active_low);
    return lit ^ active_low;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: fade ramp, period-aligned shadow level, PWM compare and pad flop.
module led_fade_channel
  import led_fade_pkg::*;
#(
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned FADE_STEP  = 4,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] target,
  input  logic                tick,
  input  logic                fade_en,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                pwm_zero,
  output logic                led_out
);

  localparam logic [PWM_BITS-1:0] MAX   = '1;
  localparam logic                UNLIT = pad_level(1'b0, ACTIVE_LOW);

  logic [PWM_BITS-1:0] work;
  logic [PWM_BITS-1:0] work_nxt;
  logic [PWM_BITS-1:0] shad;
  logic                lit_c;

  // Next working level: jump when fading is off, otherwise one saturating step per tick.
  always_comb begin
    work_nxt = work;
    if (!fade_en) begin
      work_nxt = target;
    end else if (tick) begin
      work_nxt = PWM_BITS'(step_toward(lvl_t'(work), lvl_t'(target), lvl_t'(FADE_STEP)));
    end
  end

  // Working level register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work <= '0;
    end else begin
      work <= work_nxt;
    end
  end

  // Shadow only loads at the period boundary, taking the level before any same-cycle step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shad <= '0;
    end else if (pwm_zero) begin
      shad <= work;
    end
  end

  // Full scale forces lit so the top level has no one-cycle dark gap per period.
  always_comb begin
    lit_c = (shad == MAX) | (pwm_cnt < shad);
  end

  // Registered pad drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_out <= UNLIT;
    end else begin
      led_out <= pad_level(lit_c, ACTIVE_LOW);
    end
  end

endmodule

// File: rtl/led_fade_driver.sv
// LED output stage: resynchronises the SoC LED register and drives PWM-faded pads.
module led_fade_driver
  import led_fade_pkg::*;
#(
  parameter int unsigned N_LED      = 8,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned STEP_DIV   = 4096,
  parameter int unsigned FADE_STEP  = 4,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_LED-1:0] led_in,
  input  logic             fade_en,
  output logic [N_LED-1:0] led_out,
  output logic             pwm_sync
);

  localparam int unsigned       PRE_W    = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(STEP_DIV - 1);

  logic [N_LED-1:0]    led_meta;
  logic [N_LED-1:0]    led_s;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PRE_W-1:0]    prescaler;
  logic                tick_c;
  logic                pwm_zero_c;

  // Two-flop synchroniser per bit; led_in comes from the divided SoC clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_meta <= '0;
      led_s    <= '0;
    end else begin
      led_meta <= led_in;
      led_s    <= led_meta;
    end
  end

  // Free-running PWM period counter, wraps naturally at full scale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Period-start and fade-step strobes.
  always_comb begin
    pwm_zero_c = (pwm_cnt == '0);
    tick_c     = (prescaler == PRE_LAST);
  end

  // Fade-step prescaler, counts 0..STEP_DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
    end else if (tick_c) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + PRE_W'(1);
    end
  end

  // Period-start marker, one cycle after the counter passes zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_sync <= 1'b0;
    end else begin
      pwm_sync <= pwm_zero_c;
    end
  end

  // Per-channel ramp/PWM slices; target is full scale or dark.
  for (genvar i = 0; i < N_LED; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS   (PWM_BITS),
      .FADE_STEP  (FADE_STEP),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .target   ({PWM_BITS{led_s[i]}}),
      .tick     (tick_c),
      .fade_en  (fade_en),
      .pwm_cnt  (pwm_cnt),
      .pwm_zero (pwm_zero_c),
      .led_out  (led_out[i])
    );
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// Self-checking bench for led_fade_driver with a cycle model feeding a scoreboard.
module tb_led_fade_driver;

  localparam int MAXL = 15;
  localparam int NCH  = 8;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic [7:0] led_in  = 8'h00;
  logic       fade_en = 1'b0;
  logic [7:0] led_out;
  logic       pwm_sync;

  int n_chk  = 0;
  int n_pass = 0;

  led_fade_driver #(
    .N_LED      (8),
    .PWM_BITS   (4),
    .STEP_DIV   (4),
    .FADE_STEP  (3),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .led_in   (led_in),
    .fade_en  (fade_en),
    .led_out  (led_out),
    .pwm_sync (pwm_sync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int step_to(input int cur, input int tgt);
    if (cur < tgt) return (cur + 3 > tgt) ? tgt : cur + 3;
    if (cur > tgt) return (cur - 3 < tgt) ? tgt : cur - 3;
    return cur;
  endfunction

  // Reference model state
  logic [7:0] m_meta = 8'h00;
  logic [7:0] m_s    = 8'h00;
  logic [7:0] m_nout;
  int         m_cnt  = 0;
  int         m_pre  = 0;
  bit         m_tick;
  int         m_tgt;
  int         m_work [NCH];
  int         m_shad [NCH];
  logic [8:0] exp_q  [$];
  int         per_q  [$];

  initial begin
    for (int i = 0; i < NCH; i++) begin
      m_work[i] = 0;
      m_shad[i] = 0;
    end
  end

  // Model: predicts next registered outputs at each rising edge
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_meta = 8'h00;
      m_s    = 8'h00;
      m_cnt  = 0;
      m_pre  = 0;
      for (int i = 0; i < NCH; i++) begin
        m_work[i] = 0;
        m_shad[i] = 0;
      end
      exp_q.delete();
      per_q.delete();
    end else begin
      for (int i = 0; i < NCH; i++) begin
        m_nout[i] = !((m_shad[i] == MAXL) || (m_cnt < m_shad[i]));
      end
      exp_q.push_back({(m_cnt == 0), m_nout});
      if (m_cnt == 0) begin
        per_q.push_back(m_work[7]);
        for (int i = 0; i < NCH; i++) m_shad[i] = m_work[i];
      end
      m_tick = (m_pre == 3);
      for (int i = 0; i < NCH; i++) begin
        m_tgt = m_s[i] ? MAXL : 0;
        if (!fade_en) m_work[i] = m_tgt;
        else if (m_tick) m_work[i] = step_to(m_work[i], m_tgt);
      end
      m_pre  = m_tick ? 0 : m_pre + 1;
      m_cnt  = (m_cnt + 1) % 16;
      m_s    = m_meta;
      m_meta = led_in;
    end
  end

  // Monitor: pop per-cycle expectations, and per-period low counts for channel 7
  logic [8:0] mon_e;
  int         mon_s;
  int         low_cnt   = 0;
  int         last_cnt7 = -1;
  bit         win_on    = 1'b0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      win_on  = 1'b0;
      low_cnt = 0;
    end else begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("led_out", 32'(led_out), 32'(mon_e[7:0]));
        chk("pwm_sync", 32'(pwm_sync), 32'(mon_e[8]));
      end
      if (win_on && !led_out[7]) low_cnt++;
      if (pwm_sync) begin
        if (win_on) begin
          chk("period_q_avail", 32'(per_q.size() > 0), 32'd1);
          if (per_q.size() > 0) begin
            mon_s = per_q.pop_front();
            chk("period_lowcnt_ch7", 32'(low_cnt), 32'((mon_s == MAXL) ? 16 : mon_s));
          end
          last_cnt7 = low_cnt;
        end
        win_on  = 1'b1;
        low_cnt = 0;
      end
    end
  end

  task automatic wait_lvl7(input int lvl, input string tag);
    int n;
    n = 0;
    while (m_work[7] != lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 200), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  cyc;
    bit  ok;

    // 1: reset, then idle with everything dark
    repeat (3) @(negedge clk);
    chk("rst_led_out", 32'(led_out), 32'hFF);
    chk("rst_pwm_sync", 32'(pwm_sync), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("first_sync", 32'(pwm_sync), 32'd1);
    repeat (40) @(negedge clk);

    // 2: immediate mode, channel 0 on
    led_in = 8'h01;
    cyc = 0;
    ok  = 1'b0;
    while (cyc < 24 && !ok) begin
      @(negedge clk);
      cyc++;
      #1;
      if (led_out[0] == 1'b0) ok = 1'b1;
    end
    chk("lat_ch0_lit", 32'(ok), 32'd1);
    chk("lat_ch0_le20", 32'(cyc <= 20), 32'd1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      chk("ch0_held", 32'(led_out), 32'hFE);
    end

    // 3: fade up channel 7 to saturation
    @(negedge clk);
    fade_en = 1'b1;
    led_in  = 8'h80;
    repeat (160) @(negedge clk);
    #1;
    chk("sat_ch7", 32'(last_cnt7), 32'd16);

    // 4: reverse while rising at 9, ramp down to floor
    @(negedge clk);
    fade_en = 1'b0;
    led_in  = 8'h00;
    repeat (40) @(negedge clk);
    fade_en = 1'b1;
    led_in  = 8'h80;
    wait_lvl7(9, "reach9");
    led_in = 8'h00;
    repeat (120) @(negedge clk);
    #1;
    chk("floor_ch7", 32'(last_cnt7), 32'd0);

    // 5: drop fade_en mid-ramp at 6 with full target
    @(negedge clk);
    led_in = 8'h80;
    wait_lvl7(6, "reach6");
    fade_en = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    chk("full_ch7", 32'(last_cnt7), 32'd16);

    // 6: async reset mid-period with all channels at full scale
    @(negedge clk);
    fade_en = 1'b1;
    led_in  = 8'hFF;
    repeat (100) @(negedge clk);
    cyc = 0;
    while (m_cnt != 8 && cyc < 32) begin
      @(negedge clk);
      cyc++;
    end
    chk("pre_rst_lit", 32'(led_out), 32'h00);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_led_out", 32'(led_out), 32'hFF);
    chk("async_rst_sync", 32'(pwm_sync), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (17) @(negedge clk);
    #1;
    chk("restart_ch7", 32'(last_cnt7), 32'd0);
    repeat (100) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
